// File: rtl/alu16_sequencer.sv
// Sequences ADD/ADC/SBC HL,ss over the shared 8-bit ALU as a low-byte pass then a high-byte pass,
// assembling the 16-bit result and the Z80 F register.
module alu16_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [2*DATA_WIDTH-1:0] operand_a,
  input  logic [2*DATA_WIDTH-1:0] operand_b,
  input  logic [7:0]              flags_in,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic                    alu_cin,
  output logic                    alu_sub,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_cout,
  input  logic                    alu_hout,
  input  logic                    alu_vout,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic [7:0]              flags_out
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SBC = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] a_reg;
  logic [2*DATA_WIDTH-1:0] b_reg;
  logic [1:0]              op_reg;
  logic                    keep_s;
  logic                    keep_z;
  logic                    keep_pv;
  logic                    carry_in;
  logic [DATA_WIDTH-1:0]   result_lo;
  logic                    carry_mid;

  logic [2*DATA_WIDTH-1:0] full_r;
  logic [7:0]              next_flags;

  assign full_r = {alu_result, result_lo};

  // ADD16 keeps S/Z/PV from the incoming F; ADC/SBC derive them from the full 16-bit result.
  always_comb begin
    next_flags    = 8'h00;
    next_flags[0] = alu_cout;
    next_flags[1] = (op_reg == OP_SBC);
    next_flags[3] = full_r[11];
    next_flags[4] = alu_hout;
    next_flags[5] = full_r[13];
    if (op_reg == OP_ADD) begin
      next_flags[7] = keep_s;
      next_flags[6] = keep_z;
      next_flags[2] = keep_pv;
    end else begin
      next_flags[7] = full_r[15];
      next_flags[6] = (full_r == '0);
      next_flags[2] = alu_vout;
    end
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_sub = 1'b0;
    case (state)
      LOW: begin
        alu_a   = a_reg[DATA_WIDTH-1:0];
        alu_b   = b_reg[DATA_WIDTH-1:0];
        alu_cin = (op_reg == OP_ADD) ? 1'b0 : carry_in;
        alu_sub = (op_reg == OP_SBC);
      end
      HIGH: begin
        alu_a   = a_reg[2*DATA_WIDTH-1:DATA_WIDTH];
        alu_b   = b_reg[2*DATA_WIDTH-1:DATA_WIDTH];
        alu_cin = carry_mid;
        alu_sub = (op_reg == OP_SBC);
      end
      default: ;
    endcase
  end

  // Reset mid-operation drops everything, so no done pulse can follow an aborted pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      flags_out <= 8'h00;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= 2'b00;
      keep_s    <= 1'b0;
      keep_z    <= 1'b0;
      keep_pv   <= 1'b0;
      carry_in  <= 1'b0;
      result_lo <= '0;
      carry_mid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && op != OP_RSV) begin
            a_reg    <= operand_a;
            b_reg    <= operand_b;
            op_reg   <= op;
            keep_s   <= flags_in[7];
            keep_z   <= flags_in[6];
            keep_pv  <= flags_in[2];
            carry_in <= flags_in[0];
            busy     <= 1'b1;
            state    <= LOW;
          end
        end
        LOW: begin
          result_lo <= alu_result;
          carry_mid <= alu_cout;
          state     <= HIGH;
        end
        HIGH: begin
          result    <= full_r;
          flags_out <= next_flags;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed and random checks of alu16_sequencer against a 16-bit arithmetic reference model,
// with a behavioural 8-bit ALU closing the loop around the DUT.
module tb_alu16_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [7:0]  flags_in;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic        alu_sub;
  logic [7:0]  alu_result;
  logic        alu_cout;
  logic        alu_hout;
  logic        alu_vout;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  flags_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu16_sequencer #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flags_in   (flags_in),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_sub    (alu_sub),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_hout   (alu_hout),
    .alu_vout   (alu_vout),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .flags_out  (flags_out)
  );

  // Shared 8-bit ALU stand-in: returns {v, h, c, result}.
  function automatic logic [10:0] alu_byte(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic sub);
    int x;
    int hx;
    logic [7:0] r;
    logic c;
    logic h;
    logic v;
    if (sub) begin
      x  = int'(a) - int'(b) - int'(cin);
      hx = int'(a & 8'h0F) - int'(b & 8'h0F) - int'(cin);
      r  = x[7:0];
      c  = (x < 0);
      h  = (hx < 0);
      v  = (a[7] != b[7]) && (r[7] != a[7]);
    end else begin
      x  = int'(a) + int'(b) + int'(cin);
      hx = int'(a & 8'h0F) + int'(b & 8'h0F) + int'(cin);
      r  = x[7:0];
      c  = (x > 255);
      h  = (hx > 15);
      v  = (a[7] == b[7]) && (r[7] != a[7]);
    end
    return {v, h, c, r};
  endfunction

  assign {alu_vout, alu_hout, alu_cout, alu_result} = alu_byte(alu_a, alu_b, alu_cin, alu_sub);

  // Reference: the whole instruction as one 16-bit operation.
  function automatic void model(input logic [1:0] m_op, input logic [15:0] a, input logic [15:0] b,
                                input logic [7:0] fin, output logic [15:0] r, output logic [7:0] f,
                                output logic low_carry);
    int cin;
    int full;
    int half;
    int lo;
    logic c;
    logic h;
    logic v;
    logic s;
    logic z;
    logic pv;
    cin = (m_op == 2'b00) ? 0 : int'(fin[0]);
    if (m_op == 2'b10) begin
      full      = int'(a) - int'(b) - cin;
      half      = int'(a & 16'h0FFF) - int'(b & 16'h0FFF) - cin;
      lo        = int'(a & 16'h00FF) - int'(b & 16'h00FF) - cin;
      r         = full[15:0];
      c         = (full < 0);
      h         = (half < 0);
      low_carry = (lo < 0);
      v         = (a[15] != b[15]) && (r[15] != a[15]);
    end else begin
      full      = int'(a) + int'(b) + cin;
      half      = int'(a & 16'h0FFF) + int'(b & 16'h0FFF) + cin;
      lo        = int'(a & 16'h00FF) + int'(b & 16'h00FF) + cin;
      r         = full[15:0];
      c         = (full > 65535);
      h         = (half > 4095);
      low_carry = (lo > 255);
      v         = (a[15] == b[15]) && (r[15] != a[15]);
    end
    if (m_op == 2'b00) begin
      s  = fin[7];
      z  = fin[6];
      pv = fin[2];
    end else begin
      s  = r[15];
      z  = (r == 16'h0000);
      pv = v;
    end
    f = {s, z, r[13], h, r[11], pv, (m_op == 2'b10), c};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full operation starting from IDLE, checking every pass of the sequence.
  task automatic apply_stimulus(input logic [1:0] s_op, input logic [15:0] a, input logic [15:0] b,
                                input logic [7:0] f);
    logic [15:0] er;
    logic [7:0]  ef;
    logic        lc;
    model(s_op, a, b, f, er, ef, lc);
    start     = 1'b1;
    op        = s_op;
    operand_a = a;
    operand_b = b;
    flags_in  = f;
    step();
    start     = 1'b0;
    operand_a = 16'($urandom);
    operand_b = 16'($urandom);
    flags_in  = 8'($urandom);
    op        = 2'($urandom);
    check_output("low_busy", 16'(busy), 16'd1);
    check_output("low_done", 16'(done), 16'd0);
    check_output("low_alu_a", 16'(alu_a), 16'(a[7:0]));
    check_output("low_alu_b", 16'(alu_b), 16'(b[7:0]));
    check_output("low_cin", 16'(alu_cin), (s_op == 2'b00) ? 16'd0 : 16'(f[0]));
    check_output("low_sub", 16'(alu_sub), 16'(s_op == 2'b10));
    step();
    check_output("high_alu_a", 16'(alu_a), 16'(a[15:8]));
    check_output("high_alu_b", 16'(alu_b), 16'(b[15:8]));
    check_output("high_cin", 16'(alu_cin), 16'(lc));
    check_output("high_sub", 16'(alu_sub), 16'(s_op == 2'b10));
    check_output("high_done", 16'(done), 16'd0);
    step();
    check_output("done_pulse", 16'(done), 16'd1);
    check_output("done_busy", 16'(busy), 16'd1);
    check_output("done_result", result, er);
    check_output("done_flags", 16'(flags_out), 16'(ef));
    check_output("done_alu_idle", {alu_a, alu_b}, 16'h0000);
    step();
    check_output("idle_done", 16'(done), 16'd0);
    check_output("idle_busy", 16'(busy), 16'd0);
    check_output("idle_result_held", result, er);
    check_output("idle_flags_held", 16'(flags_out), 16'(ef));
  endtask

  initial begin
    logic [15:0] er;
    logic [7:0]  ef;
    logic        lc;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 2'b00;
    operand_a = 16'h0000;
    operand_b = 16'h0000;
    flags_in  = 8'h00;
    #1;
    check_output("rst_busy", 16'(busy), 16'd0);
    check_output("rst_done", 16'(done), 16'd0);
    check_output("rst_result", result, 16'h0000);
    check_output("rst_flags", 16'(flags_out), 16'h0000);
    step();
    step();
    reset = 1'b0;
    step();

    apply_stimulus(2'b00, 16'h0FFF, 16'h0001, 8'hC4);
    check_output("tp_add_result", result, 16'h1000);
    check_output("tp_add_flags", 16'(flags_out), 16'h00D4);
    apply_stimulus(2'b01, 16'h7FFF, 16'h0000, 8'h01);
    check_output("tp_adc_result", result, 16'h8000);
    check_output("tp_adc_flags", 16'(flags_out), 16'h0094);
    apply_stimulus(2'b10, 16'h0000, 16'h0001, 8'h00);
    check_output("tp_sbc_result", result, 16'hFFFF);
    apply_stimulus(2'b10, 16'h1234, 16'h1234, 8'h00);
    check_output("tp_sbc_zero_flags", 16'(flags_out), 16'h0042);
    apply_stimulus(2'b01, 16'h0100, 16'h0000, 8'h00);
    check_output("tp_adc_lo_zero_z", 16'(flags_out[6]), 16'd0);

    // Continuous start: accepts only from IDLE, so done recurs every fourth cycle.
    start     = 1'b1;
    op        = 2'b00;
    operand_a = 16'h0001;
    operand_b = 16'h0001;
    flags_in  = 8'h00;
    for (int n = 0; n < 12; n++) begin
      step();
      check_output("held_done", 16'(done), 16'((n % 4) == 2));
      check_output("held_busy", 16'(busy), 16'((n % 4) != 3));
      if ((n % 4) == 2) check_output("held_result", result, 16'h0002);
    end
    start = 1'b0;
    step();

    start = 1'b1;
    op    = 2'b11;
    for (int n = 0; n < 4; n++) begin
      step();
      check_output("rsv_busy", 16'(busy), 16'd0);
      check_output("rsv_done", 16'(done), 16'd0);
    end
    start = 1'b0;
    step();

    // Abort during the high pass.
    start     = 1'b1;
    op        = 2'b01;
    operand_a = 16'h1234;
    operand_b = 16'h4321;
    flags_in  = 8'h01;
    step();
    start = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check_output("abort_busy", 16'(busy), 16'd0);
    check_output("abort_done", 16'(done), 16'd0);
    check_output("abort_result", result, 16'h0000);
    check_output("abort_flags", 16'(flags_out), 16'h0000);
    step();
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      check_output("abort_no_done", 16'(done), 16'd0);
    end
    apply_stimulus(2'b00, 16'hABCD, 16'h1111, 8'hFF);

    for (int i = 0; i < 60; i++) begin
      apply_stimulus(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 6; i++) begin
      lc = 1'($urandom);
      model(2'b10, 16'h8000, 16'h0001, {7'd0, lc}, er, ef, lc);
      apply_stimulus(2'b10, 16'h8000, 16'(i), 8'(i));
      apply_stimulus(2'b01, 16'hFFFF, 16'(i), 8'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
